ltssm_poll_ctrl: RTL and testbench
==================================

Name: ltssm_poll_ctrl

Overview:
Sequencer for the TS generator during LTSSM Polling. Takes the link from Detect exit through Polling.Active and Polling.Configuration, and drives ts_info/ts_update/ts_stop to the generator. It consumes the generator's sent-enough flag plus received-TS reports from the TS analyzer. Exit is to Configuration on success, or back to Detect on a 24 ms-equivalent timeout.

Parameters:
TIMEOUT_CYC, 24000, Polling timeout in clk cycles, applied separately to Active and Config; scaled for simulation.
RX_NEED, 8, consecutive matching received TSs required to advance.
UPD_LEN, 2, cycles ts_update is held high per pulse.
GAP_LEN, 1, idle cycles between the stop pulse and the load pulse.

Ports:
clk  in  1  system clock, 1 GHz
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse: Detect complete, enter Polling
ts_info  out  8  {state[7:4], sub_state[3:0]} to the TS generator
ts_update  out  1  load/stop pulse to the TS generator
ts_stop  out  1  high while no TS transmission is wanted
ts_sent_enough  in  1  generator's target TS count reached
rx_ts_valid  in  1  analyzer reports one received TS this cycle
rx_ts_is_ts2  in  1  0 = TS1, 1 = TS2; qualified by rx_ts_valid
rx_ts_ok  in  1  link/lane = PAD and rate field valid; qualified by rx_ts_valid
to_config  out  1  sticky; Polling succeeded
to_detect  out  1  one-cycle pulse on timeout
poll_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset values: ts_info = 8'h00, ts_update = 0, ts_stop = 1, to_config = 0, to_detect = 0, poll_state = IDLE (0). All counters cleared.
- All outputs are registered.
- FSM states: IDLE(0), ACT_LOAD(1), ACTIVE(2), CFG_STOP(3), CFG_GAP(4), CFG_LOAD(5), CONFIG(6), DONE(7).
- IDLE: start=1 -> ACT_LOAD. ts_info = {`POLL,`POLL_ACTIVE} on the same edge. ts_stop drops to 0.
- ACT_LOAD: ts_update held high for UPD_LEN cycles, then ACTIVE. Timeout counter cleared on entry.
- ACTIVE: rx counter counts consecutive rx_ts_valid & rx_ts_ok TSs of either type. rx_ts_valid & ~rx_ts_ok clears it to 0. The counter saturates at RX_NEED.
- ACTIVE exit: rx_cnt == RX_NEED and ts_sent_enough -> CFG_STOP.
- CFG_STOP: ts_update high for UPD_LEN cycles; this returns the generator to its await state.
- CFG_GAP: GAP_LEN cycles with ts_update low. ts_info is updated to {`POLL,`POLL_CFG} in this state.
- CFG_LOAD: ts_update high for UPD_LEN cycles -> CONFIG. The rx counter and timeout counter are cleared on entry.
- Generator handshake: ts_update pulses are never back-to-back. At least one low cycle separates the stop and load pulses.
- CONFIG: the rx counter counts only consecutive rx_ts_valid & rx_ts_ok & rx_ts_is_ts2. Any other valid TS clears it.
- CONFIG exit: rx_cnt == RX_NEED and ts_sent_enough -> DONE.
- DONE: to_config = 1 (sticky), ts_stop = 1, and one stop pulse is issued on ts_update. DONE is left only by reset.
- Timeout: a 16-bit counter increments each cycle in ACTIVE and CONFIG. When it reaches TIMEOUT_CYC-1:
  - to_detect pulses for 1 cycle;
  - a stop pulse (UPD_LEN) is issued;
  - ts_stop = 1 and ts_info = 8'h00;
  - FSM -> IDLE once the pulse completes.
- Simultaneous events: if the success condition and the timeout fire in the same cycle, success wins.
- rx_ts_valid received during the LOAD/STOP/GAP states is ignored.
- start while not in IDLE is ignored.
- Reset mid-operation: everything returns to reset values immediately; no stop pulse is issued.
- ts_sent_enough is sampled only in ACTIVE/CONFIG. It is not latched.

Decomposition:
- Shared define file gains: `POLL_CFG sub-state code, `CFG state code, and the poll_state encodings.
- Existing `POLL / `POLL_ACTIVE codes are reused.
- Sub-module upd_pulser: given a trigger, emits an UPD_LEN-cycle high pulse and a done strobe. It is used for load and stop pulses. The consecutive-TS counter stays inline.

Test Plan:
- Reset, then start. Required:
  - ts_info = 8'h2? matching {`POLL,`POLL_ACTIVE};
  - ts_update high exactly 2 cycles;
  - ts_stop = 0;
  - poll_state 1 -> 2.
- In ACTIVE, feed 8 valid ok TS1s with ts_sent_enough = 1. Required:
  - ts_update pattern 1,1,0,1,1;
  - ts_info changes to {`POLL,`POLL_CFG} during the gap;
  - poll_state reaches 6.
- In ACTIVE, feed 7 good TSs, 1 with rx_ts_ok = 0, then 7 good. Required: no transition; after 1 more good TS, transition occurs.
- In CONFIG, feed TS2 x5, TS1, TS2 x8, with sent_enough = 1. Required: DONE only after the 8th trailing TS2; to_config = 1 and stays high.
- No rx input, TIMEOUT_CYC = 100. Required:
  - to_detect pulses at cycle 100 after ACTIVE entry;
  - stop pulse issued;
  - ts_stop = 1;
  - poll_state = 0.
- Success and timeout in the same cycle -> DONE and no to_detect. Separately, assert rst mid-CFG_GAP -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/ltssm_poll_ctrl_pkg.sv
// ltssm_poll_ctrl_pkg: shared LTSSM state/sub-state codes and poll FSM encodings
package ltssm_poll_ctrl_pkg;
  localparam logic [3:0] POLL        = 4'h2;
  localparam logic [3:0] CFG         = 4'h3;
  localparam logic [3:0] POLL_ACTIVE = 4'h1;
  localparam logic [3:0] POLL_CFG    = 4'h3;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ACT_LOAD = 3'd1;
  localparam logic [2:0] ST_ACTIVE   = 3'd2;
  localparam logic [2:0] ST_CFG_STOP = 3'd3;
  localparam logic [2:0] ST_CFG_GAP  = 3'd4;
  localparam logic [2:0] ST_CFG_LOAD = 3'd5;
  localparam logic [2:0] ST_CONFIG   = 3'd6;
  localparam logic [2:0] ST_DONE     = 3'd7;
  function automatic logic [7:0] ts_code(input logic [3:0] st, input logic [3:0] sub);
    return {st, sub};
  endfunction
endpackage

// File: rtl/ltssm_poll_ctrl_upd_pulser.sv
// ltssm_poll_ctrl_upd_pulser: LEN-cycle registered pulse per trigger, done strobe on its last cycle
// Ports: clk, rst (sync, active-high), trig_i (ignored while busy), pulse_o (registered), done_o
module ltssm_poll_ctrl_upd_pulser #(
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic trig_i,
  output logic pulse_o,
  output logic done_o
);
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  logic busy_q;
  logic [CW-1:0] cnt_q;
  assign pulse_o = busy_q;
  assign done_o = busy_q && cnt_q == CW'(LEN - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (!busy_q) begin
      busy_q <= trig_i;
      cnt_q  <= '0;
    end else begin
      busy_q <= !done_o;
      cnt_q  <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/ltssm_poll_ctrl.sv
// ltssm_poll_ctrl: Polling sequencer driving the TS generator from Detect exit to Configuration
// Ports: start (Detect done pulse), ts_info/ts_update/ts_stop (to generator), ts_sent_enough,
//        rx_ts_valid/rx_ts_is_ts2/rx_ts_ok (from analyzer), to_config (sticky), to_detect (pulse),
//        poll_state (debug). All outputs registered.
module ltssm_poll_ctrl
  import ltssm_poll_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 24000,
  parameter int RX_NEED     = 8,
  parameter int UPD_LEN     = 2,
  parameter int GAP_LEN     = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] ts_info,
  output logic       ts_update,
  output logic       ts_stop,
  input  logic       ts_sent_enough,
  input  logic       rx_ts_valid,
  input  logic       rx_ts_is_ts2,
  input  logic       rx_ts_ok,
  output logic       to_config,
  output logic       to_detect,
  output logic [2:0] poll_state
);
  localparam int RW = $clog2(RX_NEED + 1);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  logic [2:0] state_q, state_d;
  logic [7:0] ts_info_q, ts_info_d;
  logic ts_stop_q, ts_stop_d, to_config_q, to_config_d, to_detect_q, to_detect_d;
  logic abort_q, abort_d;
  logic [RW-1:0] rx_q, rx_d;
  logic [15:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic trig, done, counting, rx_good, success, timeout;
  ltssm_poll_ctrl_upd_pulser #(.LEN(UPD_LEN)) u_pulser (
    .clk    (clk),
    .rst    (rst),
    .trig_i (trig),
    .pulse_o(ts_update),
    .done_o (done)
  );
  // abort_q marks a timeout stop pulse in flight; the state is held until it completes
  always_comb begin
    counting = (state_q == ST_ACTIVE || state_q == ST_CONFIG) && !abort_q;
    rx_good = rx_ts_ok && (state_q != ST_CONFIG || rx_ts_is_ts2);
    success = counting && rx_q == RW'(RX_NEED) && ts_sent_enough;
    timeout = counting && tmo_q == 16'(TIMEOUT_CYC - 1);
    rx_d = !counting ? '0 : !rx_ts_valid ? rx_q : !rx_good ? '0 :
           rx_q == RW'(RX_NEED) ? rx_q : rx_q + 1'b1;
    tmo_d = counting ? tmo_q + 16'd1 : '0;
    gap_d = state_q == ST_CFG_GAP ? gap_q + 1'b1 : '0;
    state_d = state_q;
    ts_info_d = ts_info_q;
    ts_stop_d = ts_stop_q;
    to_config_d = to_config_q;
    to_detect_d = 1'b0;
    abort_d = abort_q;
    trig = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_ACT_LOAD;
        ts_info_d = ts_code(POLL, POLL_ACTIVE);
        ts_stop_d = 1'b0;
        trig = 1'b1;
      end
      ST_ACT_LOAD: state_d = done ? ST_ACTIVE : state_q;
      ST_ACTIVE, ST_CONFIG: if (success) begin
        state_d = state_q == ST_ACTIVE ? ST_CFG_STOP : ST_DONE;
        trig = 1'b1;
        if (state_q == ST_CONFIG) begin
          to_config_d = 1'b1;
          ts_stop_d = 1'b1;
          ts_info_d = ts_code(CFG, 4'h0);
        end
      end else if (timeout) begin
        to_detect_d = 1'b1;
        trig = 1'b1;
        ts_stop_d = 1'b1;
        ts_info_d = 8'h00;
        abort_d = 1'b1;
      end else if (abort_q && done) begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end
      ST_CFG_STOP: if (done) begin
        state_d = ST_CFG_GAP;
        ts_info_d = ts_code(POLL, POLL_CFG);
      end
      ST_CFG_GAP: if (gap_q == GW'(GAP_LEN - 1)) begin
        state_d = ST_CFG_LOAD;
        trig = 1'b1;
      end
      ST_CFG_LOAD: state_d = done ? ST_CONFIG : state_q;
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ts_info_q   <= 8'h00;
      ts_stop_q   <= 1'b1;
      to_config_q <= 1'b0;
      to_detect_q <= 1'b0;
      abort_q     <= 1'b0;
      rx_q        <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      ts_info_q   <= ts_info_d;
      ts_stop_q   <= ts_stop_d;
      to_config_q <= to_config_d;
      to_detect_q <= to_detect_d;
      abort_q     <= abort_d;
      rx_q        <= rx_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
    end
  end
  assign ts_info = ts_info_q;
  assign ts_stop = ts_stop_q;
  assign to_config = to_config_q;
  assign to_detect = to_detect_q;
  assign poll_state = state_q;
endmodule

// File: tb/tb_ltssm_poll_ctrl.sv
// tb_ltssm_poll_ctrl: directed self-checking bench for ltssm_poll_ctrl with a 100-cycle timeout
module tb_ltssm_poll_ctrl;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, ts_sent_enough = 1'b0;
  logic rx_ts_valid = 1'b0, rx_ts_is_ts2 = 1'b0, rx_ts_ok = 1'b0;
  logic [7:0] ts_info;
  logic ts_update, ts_stop, to_config, to_detect;
  logic [2:0] poll_state;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ltssm_poll_ctrl #(.TIMEOUT_CYC(100), .RX_NEED(8), .UPD_LEN(2), .GAP_LEN(1)) dut (
    .clk(clk), .rst(rst), .start(start), .ts_info(ts_info), .ts_update(ts_update),
    .ts_stop(ts_stop), .ts_sent_enough(ts_sent_enough), .rx_ts_valid(rx_ts_valid),
    .rx_ts_is_ts2(rx_ts_is_ts2), .rx_ts_ok(rx_ts_ok), .to_config(to_config),
    .to_detect(to_detect), .poll_state(poll_state)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic rx(input logic v, input logic t2, input logic ok);
    rx_ts_valid = v;
    rx_ts_is_ts2 = t2;
    rx_ts_ok = ok;
  endtask
  task automatic good(input int n, input logic t2);
    repeat (n) begin
      rx(1'b1, t2, 1'b1);
      tick();
    end
    rx(1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    ts_sent_enough = 1'b0;
    rx(1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic go_active();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_info"}, ts_info, 8'h00);
    chk({tag, "_upd"}, {7'd0, ts_update}, 8'd0);
    chk({tag, "_stop"}, {7'd0, ts_stop}, 8'd1);
    chk({tag, "_cfg"}, {7'd0, to_config}, 8'd0);
    chk({tag, "_det"}, {7'd0, to_detect}, 8'd0);
    chk({tag, "_st"}, {5'd0, poll_state}, 8'd0);
  endtask
  initial begin
    do_reset();
    chk_reset_vals("rst");
    // start -> ACT_LOAD with 2-cycle load pulse, then ACTIVE
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_st", {5'd0, poll_state}, 8'd1);
    chk("start_info", ts_info, 8'h21);
    chk("start_stop", {7'd0, ts_stop}, 8'd0);
    chk("load_upd0", {7'd0, ts_update}, 8'd1);
    tick();
    chk("load_st1", {5'd0, poll_state}, 8'd1);
    chk("load_upd1", {7'd0, ts_update}, 8'd1);
    tick();
    chk("act_st", {5'd0, poll_state}, 8'd2);
    chk("act_upd", {7'd0, ts_update}, 8'd0);
    // start outside IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ign", {5'd0, poll_state}, 8'd2);
    // 8 good TS1 with sent_enough -> stop / gap / load -> CONFIG
    ts_sent_enough = 1'b1;
    good(8, 1'b0);
    chk("act_hold", {5'd0, poll_state}, 8'd2);
    tick();
    chk("cs_st", {5'd0, poll_state}, 8'd3);
    chk("cs_upd0", {7'd0, ts_update}, 8'd1);
    tick();
    chk("cs_upd1", {7'd0, ts_update}, 8'd1);
    tick();
    chk("gap_st", {5'd0, poll_state}, 8'd4);
    chk("gap_upd", {7'd0, ts_update}, 8'd0);
    chk("gap_info", ts_info, 8'h23);
    tick();
    chk("cl_st", {5'd0, poll_state}, 8'd5);
    chk("cl_upd0", {7'd0, ts_update}, 8'd1);
    tick();
    chk("cl_upd1", {7'd0, ts_update}, 8'd1);
    tick();
    chk("cfg_st", {5'd0, poll_state}, 8'd6);
    chk("cfg_upd", {7'd0, ts_update}, 8'd0);
    // CONFIG: TS2 x5, TS1 breaks the run, then 8 TS2 needed
    good(5, 1'b1);
    good(1, 1'b0);
    good(7, 1'b1);
    tick();
    chk("cfg_7ts2", {5'd0, poll_state}, 8'd6);
    good(1, 1'b1);
    tick();
    chk("done_st", {5'd0, poll_state}, 8'd7);
    chk("done_cfg", {7'd0, to_config}, 8'd1);
    chk("done_stop", {7'd0, ts_stop}, 8'd1);
    chk("done_upd0", {7'd0, ts_update}, 8'd1);
    tick();
    chk("done_upd1", {7'd0, ts_update}, 8'd1);
    tick();
    tick();
    chk("done_upd2", {7'd0, ts_update}, 8'd0);
    chk("done_sticky", {7'd0, to_config}, 8'd1);
    chk("done_stay", {5'd0, poll_state}, 8'd7);
    // ACTIVE: a bad TS restarts the consecutive count
    do_reset();
    go_active();
    ts_sent_enough = 1'b1;
    good(7, 1'b0);
    rx(1'b1, 1'b0, 1'b0);
    tick();
    good(7, 1'b0);
    tick();
    chk("bad_hold", {5'd0, poll_state}, 8'd2);
    good(1, 1'b0);
    tick();
    chk("bad_adv", {5'd0, poll_state}, 8'd3);
    // timeout in ACTIVE with no rx
    do_reset();
    go_active();
    repeat (99) tick();
    chk("tmo_pre_det", {7'd0, to_detect}, 8'd0);
    chk("tmo_pre_st", {5'd0, poll_state}, 8'd2);
    tick();
    chk("tmo_det", {7'd0, to_detect}, 8'd1);
    chk("tmo_upd0", {7'd0, ts_update}, 8'd1);
    chk("tmo_stop", {7'd0, ts_stop}, 8'd1);
    chk("tmo_info", ts_info, 8'h00);
    tick();
    chk("tmo_det_off", {7'd0, to_detect}, 8'd0);
    chk("tmo_upd1", {7'd0, ts_update}, 8'd1);
    tick();
    chk("tmo_idle", {5'd0, poll_state}, 8'd0);
    chk("tmo_upd2", {7'd0, ts_update}, 8'd0);
    chk("tmo_stop2", {7'd0, ts_stop}, 8'd1);
    // success and timeout on the same cycle in CONFIG: success wins
    do_reset();
    go_active();
    ts_sent_enough = 1'b1;
    good(8, 1'b0);
    repeat (6) tick();
    chk("race_cfg", {5'd0, poll_state}, 8'd6);
    ts_sent_enough = 1'b0;
    repeat (99) begin
      rx(1'b1, 1'b1, 1'b1);
      tick();
    end
    rx(1'b0, 1'b0, 1'b0);
    chk("race_pre", {5'd0, poll_state}, 8'd6);
    ts_sent_enough = 1'b1;
    tick();
    chk("race_st", {5'd0, poll_state}, 8'd7);
    chk("race_det", {7'd0, to_detect}, 8'd0);
    chk("race_cfgo", {7'd0, to_config}, 8'd1);
    tick();
    chk("race_det2", {7'd0, to_detect}, 8'd0);
    // reset in CFG_GAP
    do_reset();
    go_active();
    ts_sent_enough = 1'b1;
    good(8, 1'b0);
    repeat (3) tick();
    chk("mid_gap", {5'd0, poll_state}, 8'd4);
    rst = 1'b1;
    tick();
    chk_reset_vals("mrst");
    rst = 1'b0;
    tick();
    chk_reset_vals("mrst_rel");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
